// File: rtl/pio_source_pkg.sv
// ============================================================================
// pio_source_pkg : opcodes, response tags and FSM states for logistic_pio_source
// Revision: 1.0
// ============================================================================
`default_nettype none

package pio_source_pkg;

    localparam logic [3:0] OP_IDLE   = 4'h0;
    localparam logic [3:0] OP_READ   = 4'h3;
    localparam logic [3:0] OP_STEP   = 4'h6;
    localparam logic [3:0] OP_RELOAD = 4'h9;

    localparam logic [7:0] TAG_STEP   = 8'h45;
    localparam logic [7:0] TAG_READ   = 8'h48;
    localparam logic [7:0] TAG_RELOAD = 8'h52;
    localparam logic [7:0] TAG_ERR    = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL1 = 2'd1,
        ST_MUL2 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic [31:0] pack_resp(input logic [3:0]  seq,
                                              input logic [3:0]  ch,
                                              input logic [7:0]  tag,
                                              input logic [15:0] data);
        return {seq, ch, tag, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/logistic_step.sv
// ============================================================================
// logistic_step : two-stage fixed-point x_next = ((r*x)>>F) * (ONE-x) >> F
// Revision: 1.0
// ============================================================================
`default_nettype none

module logistic_step #(
    parameter int FRAC_BITS = 28
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load,
    input  logic [63:0] x,
    input  logic [63:0] r,
    output logic [63:0] x_next
);

    localparam logic [63:0] ONE = 64'd1 << FRAC_BITS;

    logic [63:0] x_in_q, x_in_d;
    logic [63:0] r_in_q, r_in_d;
    logic [63:0] p1_q, p1_d;
    logic [63:0] omx_q, omx_d;

    // Stage 1 captures the operands on load; stage 2 holds r*x and ONE-x.
    always_comb begin
        x_in_d = load ? x : x_in_q;
        r_in_d = load ? r : r_in_q;
        p1_d   = 64'((128'(r_in_q) * 128'(x_in_q)) >> FRAC_BITS);
        omx_d  = ONE - x_in_q;
        x_next = 64'((128'(p1_q) * 128'(omx_q)) >> FRAC_BITS);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_in_q <= '0;
            r_in_q <= '0;
            p1_q   <= '0;
            omx_q  <= '0;
        end else begin
            x_in_q <= x_in_d;
            r_in_q <= r_in_d;
            p1_q   <= p1_d;
            omx_q  <= omx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/logistic_pio_source.sv
// ============================================================================
// logistic_pio_source : tick-sampled PIO command front end over NUM_CH
//                       logistic-map channels
// Revision: 1.0
// ============================================================================
`default_nettype none

module logistic_pio_source
    import pio_source_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          FRAC_BITS = 28,
    parameter logic [63:0] R_Q       = 64'd4 << FRAC_BITS,
    parameter logic [63:0] SEED      = 64'h0000000003e44970,
    parameter int          PERIOD    = 40
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] outputPio,
    output logic [31:0] inputPio
);

    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);
    localparam logic [7:0] TICK_MAX = 8'(PERIOD - 1);

    state_e      state_q, state_d;
    logic [7:0]  tick_cnt_q, tick_cnt_d;
    logic [31:0] last_q, last_d;
    logic [3:0]  seq_q, seq_d;
    logic [31:0] pio_q, pio_d;
    logic [3:0]  step_ch_q, step_ch_d;
    logic [63:0] x_q [NUM_CH];
    logic [63:0] x_d [NUM_CH];

    logic        tick, load, ch_ok;
    logic [3:0]  cmd_op, cmd_ch;
    logic [3:0]  seq_inc;
    logic [63:0] sel_x, x_next;

    logistic_step #(.FRAC_BITS(FRAC_BITS)) u_step (
        .clock  (clock),
        .resetn (resetn),
        .load   (load),
        .x      (sel_x),
        .r      (R_Q),
        .x_next (x_next)
    );

    always_comb begin
        tick       = (tick_cnt_q == 8'd0);
        tick_cnt_d = (tick_cnt_q == TICK_MAX) ? 8'd0 : tick_cnt_q + 8'd1;
        cmd_op     = outputPio[3:0];
        cmd_ch     = outputPio[7:4];
        ch_ok      = ({1'b0, cmd_ch} < NUM_CH_W);
        seq_inc    = seq_q + 4'd1;
        sel_x      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_ch == 4'(i)) sel_x = x_q[i];
        end

        state_d   = state_q;
        last_d    = last_q;
        seq_d     = seq_q;
        pio_d     = pio_q;
        step_ch_d = step_ch_q;
        load      = 1'b0;
        x_d       = x_q;

        case (state_q)
            ST_IDLE: begin
                // Ticks only sample; a word equal to the last accepted one is a held command.
                if (tick && (outputPio != last_q)) begin
                    last_d = outputPio;
                    if (cmd_op == OP_IDLE) begin
                        state_d = ST_IDLE;
                    end else if (!ch_ok || !(cmd_op == OP_STEP || cmd_op == OP_READ
                                             || cmd_op == OP_RELOAD)) begin
                        pio_d   = pack_resp(seq_inc, cmd_ch, TAG_ERR, outputPio[15:0]);
                        seq_d   = seq_inc;
                        state_d = ST_RESP;
                    end else if (cmd_op == OP_STEP) begin
                        load      = 1'b1;
                        step_ch_d = cmd_ch;
                        state_d   = ST_MUL1;
                    end else if (cmd_op == OP_READ) begin
                        pio_d   = pack_resp(seq_inc, cmd_ch, TAG_READ, sel_x[15:0]);
                        seq_d   = seq_inc;
                        state_d = ST_RESP;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cmd_ch == 4'(i)) x_d[i] = SEED;
                        end
                        pio_d   = pack_resp(seq_inc, cmd_ch, TAG_RELOAD, SEED[15:0]);
                        seq_d   = seq_inc;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_MUL1: state_d = ST_MUL2;
            ST_MUL2: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (step_ch_q == 4'(i)) x_d[i] = x_next;
                end
                pio_d   = pack_resp(seq_inc, step_ch_q, TAG_STEP, x_next[31:16]);
                seq_d   = seq_inc;
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= 8'd0;
            last_q     <= 32'h0;
            seq_q      <= 4'd0;
            pio_q      <= 32'h0;
            step_ch_q  <= 4'd0;
            for (int i = 0; i < NUM_CH; i++) x_q[i] <= SEED;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            last_q     <= last_d;
            seq_q      <= seq_d;
            pio_q      <= pio_d;
            step_ch_q  <= step_ch_d;
            for (int i = 0; i < NUM_CH; i++) x_q[i] <= x_d[i];
        end
    end

    assign inputPio = pio_q;

endmodule

`default_nettype wire
